fetch_unit: RTL

- Instruction fetch stage directly upstream of the unified memory block.
- Drives word addresses into memory and captures returned words into a small prefetch FIFO.
- Presents {instr, instr_pc} to decode with a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP    = 32'd4;
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wr_data_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output fetch_entry_t     head_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop so a redirect leaves nothing stale.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch with 1-cycle memory, prefetch FIFO, redirect flush.
// Define FETCH_BYPASS_EN to present a returning word in its capture cycle when the FIFO is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CRED_W = CNT_W + 1;
    localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(DEPTH);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       issued_pc_q, issued_pc_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      fifo_head;
    fetch_entry_t      cap_entry;
    fetch_entry_t      out_entry;
    logic [CRED_W-1:0] credits_used;
    logic              issue;
    logic              capture;
    logic              push;
    logic              pop;
    logic              out_valid;
`ifdef FETCH_BYPASS_EN
    logic              bypass;
`endif

    // An in-flight word already owns a FIFO slot, so issue only while a slot stays free.
    assign credits_used = CRED_W'(fifo_count) + CRED_W'(inflight_q);
    assign issue        = !reset && !branch_valid && (credits_used < DEPTH_C);
    assign capture      = inflight_q && !branch_valid;
    assign cap_entry    = '{pc: issued_pc_q, instr: mem_data};

    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass    = capture && fifo_empty;
        out_valid = !fifo_empty || bypass;
        out_entry = fifo_empty ? cap_entry : fifo_head;
        push      = capture && !(bypass && instr_ready);
        pop       = !branch_valid && !fifo_empty && instr_ready;
`else
        out_valid = !fifo_empty;
        out_entry = fifo_head;
        push      = capture;
        pop       = !branch_valid && out_valid && instr_ready;
`endif
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        if (branch_valid) begin
            fetch_pc_d = align_pc(branch_target);
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + PC_STEP;
            issued_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_i    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (branch_valid),
        .wr_data_i(cap_entry),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (fifo_head)
    );

    no_overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

    // Handshake: a word transfers on any cycle with instr_valid && instr_ready and no redirect.
    assign mem_address = fetch_pc_q;
    assign mem_read    = issue;
    assign mem_write   = 1'b0;
    assign instr_valid = out_valid;
    assign instr       = out_valid ? out_entry.instr : '0;
    assign instr_pc    = out_valid ? out_entry.pc : '0;

endmodule
